instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage of the RISC-V core. Owns the PC and issues word requests to instruction memory over a valid/ready port.
//   Buffers returned instructions in a small in-order FIFO and presents the head to decode.
//   Decode receives the instruction as raw fields: opcode, funct3 and funct7 feed control_unit directly.
//   Handles decode stalls and branch redirects, including discarding responses still in flight at redirect time.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset (bits[1:0] must be 0)
//   FIFO_DEPTH  2              instruction buffer entries; also the credit limit on requests (2..8)
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   asynchronous, active-high reset
//   imem_req_valid  out  1   fetch request valid
//   imem_req_ready  in   1   memory accepts request this cycle
//   imem_req_addr   out  32  word-aligned fetch address
//   imem_rsp_valid  in   1   response valid; responses return in request order, >=1 cycle after acceptance
//   imem_rsp_data   in   32  instruction word
//   redirect_valid  in   1   branch/jump taken; restart fetch at redirect_pc
//   redirect_pc     in   32  new PC; bits[1:0] ignored (forced 0)
//   stall           in   1   decode cannot accept the instruction this cycle
//   if_valid        out  1   if_pc/if_instr/fields valid
//   if_pc           out  32  PC of the presented instruction
//   if_instr        out  32  presented instruction
//   opcode          out  7   if_instr[6:0]
//   funct3          out  3   if_instr[14:12]
//   funct7          out  7   if_instr[31:25]
// BEHAVIOUR
//   Reset (async): pc=RESET_PC, FIFO empty, outstanding=0, drop=0, state=RUN.
//     Outputs at reset: imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0.
//   Credit: imem_req_valid=1 iff state==RUN && !redirect_valid && (outstanding + fifo_count) < FIFO_DEPTH.
//   Request accept: on imem_req_valid & imem_req_ready, pc += 4 (mod 2^32, wraps) and outstanding += 1.
//     imem_req_addr = pc and holds stable while valid && !ready.
//   Response: on imem_rsp_valid, outstanding -= 1.
//     drop==0: push {pc_of_req, data}; request PCs are tracked in a FIFO_DEPTH-deep tag queue.
//     drop!=0: discard the response; drop -= 1.
//   Consume: when if_valid && !stall, pop the head.
//     Push and pop in the same cycle are both legal, including when the FIFO is full.
//   Output: if_valid = FIFO non-empty && state==RUN. Fields are driven combinationally from the head entry.
//   FSM:
//     RUN: redirect_valid -> FLUSH if outstanding (after this cycle's response) > 0, else stay in RUN.
//     FLUSH: no requests issued, if_valid=0; -> RUN when drop reaches 0.
//     redirect_valid in FLUSH: reload pc and stay in FLUSH.
//   On redirect (any state):
//     - flush FIFO and tag queue; pc = {redirect_pc[31:2],2'b00};
//     - drop = outstanding_next (including a request accepted this same cycle);
//     - a response arriving in the redirect cycle is discarded and not counted in drop.
//   Priority: rst > redirect_valid > stall.
//     A redirect in the same cycle as pop/push cancels both. A stall never blocks a redirect.
//   Latency:
//     - request accepted at cycle N, response at N+k -> if_valid at N+k+1 (registered push).
//     - after a redirect with outstanding==0: first request issued the next cycle.
//   Reset mid-operation: all state cleared immediately; responses arriving after rst deasserts are not expected.
// TESTING
//   1 Reset: rst=1 then release, 1-cycle memory -> reqs 0x0,0x4,0x8...; if_pc=0x0 with if_instr=mem[0] 2 cycles after release.
//   2 Stall: stall=1 for 5 cycles, FIFO_DEPTH=2 -> at most 2 reqs outstanding/buffered; imem_req_valid=0; if_pc held. Release -> stream resumes in order, no loss or duplicates.
//   3 Redirect in flight: 2 outstanding, redirect_pc=0x100 -> both responses discarded, FLUSH 2 responses, next req addr=0x100, if_pc=0x100.
//   4 Same-cycle: redirect with rsp_valid and stall=1 -> response dropped; redirect taken; FIFO empty next cycle.
//   5 Misaligned redirect: redirect_pc=0x0000_0206 -> imem_req_addr=0x204.
//   6 Wrap and backpressure: pc=0xFFFF_FFFC with ready low for 3 cycles -> address stable; after accept pc=0x0.
//     Decoded fields for instr 0x4000_8033: opcode=0110011, funct3=000, funct7=0100000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : RISC-V fetch stage. Owns the PC, issues credit-limited word
//               requests to instruction memory, buffers in-order responses in
//               a small FIFO and presents the head (with raw decode fields) to
//               decode. Branch redirects flush the buffer and discard any
//               responses still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam int c_idx_w = $clog2(FIFO_DEPTH);
  localparam int c_sum_w = c_cnt_w + 1;
  localparam logic [c_sum_w-1:0] c_depth = c_sum_w'(FIFO_DEPTH);
  localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(FIFO_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             r_state, w_state_next;
  logic [31:0]        r_pc;
  logic [c_cnt_w-1:0] r_outst, r_drop, r_cnt;
  logic [c_cnt_w-1:0] w_outst_next, w_drop_next;
  logic [c_idx_w-1:0] r_rd_ptr, r_wr_ptr, r_tag_rd, r_tag_wr;
  logic [31:0]        r_buf_pc    [FIFO_DEPTH];
  logic [31:0]        r_buf_instr [FIFO_DEPTH];
  logic [31:0]        r_tag       [FIFO_DEPTH];
  logic [c_sum_w-1:0] w_used;
  logic               w_run, w_req_fire, w_rsp_keep, w_rsp_drop, w_pop;
  logic               w_unused_bits;

  // Circular pointer advance that also works for non power-of-two depths.
  function automatic logic [c_idx_w-1:0] f_inc(input logic [c_idx_w-1:0] i_p);
    return (i_p == c_last) ? '0 : i_p + 1'b1;
  endfunction

  // The two low redirect bits are forced to zero and therefore unused.
  assign w_unused_bits = ^redirect_pc[1:0];

  assign w_run  = (r_state == ST_RUN);
  // Credit counts both in-flight requests and buffered instructions.
  assign w_used = c_sum_w'(r_outst) + c_sum_w'(r_cnt);

  // Reset gate keeps the port quiet while the async reset is held.
  assign imem_req_valid = ~rst & w_run & ~redirect_valid & (w_used < c_depth);
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  // Responses in the redirect cycle are neither kept nor counted as dropped.
  assign w_rsp_keep   = imem_rsp_valid & ~redirect_valid & (r_drop == '0);
  assign w_rsp_drop   = imem_rsp_valid & ~redirect_valid & (r_drop != '0);
  assign w_outst_next = r_outst + c_cnt_w'(w_req_fire) - c_cnt_w'(imem_rsp_valid);
  assign w_drop_next  = r_drop - c_cnt_w'(w_rsp_drop);

  assign if_valid = w_run & (r_cnt != '0);
  assign w_pop    = if_valid & ~stall & ~redirect_valid;
  assign if_pc    = if_valid ? r_buf_pc[r_rd_ptr]    : 32'h0;
  assign if_instr = if_valid ? r_buf_instr[r_rd_ptr] : 32'h0;
  assign opcode   = if_instr[6:0];
  assign funct3   = if_instr[14:12];
  assign funct7   = if_instr[31:25];

  // Next-state: FLUSH while stale responses remain to be discarded.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (redirect_valid && (w_outst_next != '0)) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!redirect_valid && (w_drop_next == '0)) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  // PC, credit counters and queue pointers; a redirect overrides push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_outst  <= '0;
      r_drop   <= '0;
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_tag_rd <= '0;
      r_tag_wr <= '0;
    end else begin
      r_outst <= w_outst_next;
      if (redirect_valid) begin
        r_pc     <= {redirect_pc[31:2], 2'b00};
        r_drop   <= w_outst_next;
        r_cnt    <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_tag_rd <= '0;
        r_tag_wr <= '0;
      end else begin
        if (w_req_fire) begin
          r_pc     <= r_pc + 32'd4;
          r_tag_wr <= f_inc(r_tag_wr);
        end
        if (w_rsp_keep) begin
          r_tag_rd <= f_inc(r_tag_rd);
          r_wr_ptr <= f_inc(r_wr_ptr);
        end
        if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
        r_cnt  <= r_cnt + c_cnt_w'(w_rsp_keep) - c_cnt_w'(w_pop);
        r_drop <= w_drop_next;
      end
    end
  end

  // Tag queue and instruction buffer storage; contents only matter when counted valid.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_tag[r_tag_wr] <= r_pc;
    if (w_rsp_keep) begin
      r_buf_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
      r_buf_instr[r_wr_ptr] <= imem_rsp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. An in-order memory
//               model with random latency feeds the DUT; a stream-level model
//               (expected PC sequence, credit and flush accounting) checks
//               every request and every instruction handed to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall, if_valid;
  logic [31:0] if_pc, if_instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // memory model: in-order outstanding requests with due cycle
  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  // stream model
  logic [31:0] m_next_req, m_exp_pc;
  int          m_cnt, m_drop, n_consumed;
  bit          m_flush;

  // stimulus knobs
  int          rdy_mode, stall_mode, lat_min, lat_max, redir_pct;
  bit          rsp_rand, redir_now;
  logic [31:0] redir_target;

  // per-cycle samples
  logic        s_req_valid, s_if_valid, s_acc, s_pop, s_rsp;
  logic [31:0] s_req_addr, s_if_pc, s_if_instr;
  logic [6:0]  s_opcode, s_funct7;
  logic [2:0]  s_funct3;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'hFFFF_FFFC) return 32'h4000_8033;
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    mq_addr.delete();
    mq_due.delete();
    m_next_req = 32'h0;
    m_exp_pc   = 32'h0;
    m_cnt      = 0;
    m_drop     = 0;
    m_flush    = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, sample/check 1ns later, advance models.
  task automatic tick();
    bit exp_req, exp_ifv;
    imem_req_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    stall          = (stall_mode == 2) ? ($urandom_range(0, 2) == 0) : (stall_mode == 1);
    if (mq_addr.size() > 0 && mq_due[0] <= cyc && (!rsp_rand || $urandom_range(0, 3) != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    redirect_valid = redir_now || ($urandom_range(0, 99) < redir_pct);
    redirect_pc    = redir_now ? redir_target : $urandom;
    #1;
    s_req_valid = imem_req_valid;  s_req_addr = imem_req_addr;
    s_if_valid  = if_valid;        s_if_pc    = if_pc;       s_if_instr = if_instr;
    s_opcode    = opcode;          s_funct3   = funct3;      s_funct7   = funct7;
    s_rsp       = imem_rsp_valid;
    exp_req = !m_flush && !redirect_valid && (mq_addr.size() + m_cnt < DEPTH);
    exp_ifv = !m_flush && (m_cnt > 0);
    n_cmp++;
    if (imem_req_valid !== exp_req) begin
      n_err++;
      $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, imem_req_valid, exp_req);
    end
    n_cmp++;
    if (if_valid !== exp_ifv) begin
      n_err++;
      $display("FAIL if_valid cyc=%0d: got %b expected %b", cyc, if_valid, exp_ifv);
    end
    s_acc = imem_req_valid && imem_req_ready;
    s_pop = if_valid && !stall && !redirect_valid;
    if (imem_rsp_valid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      if (!redirect_valid) begin
        if (m_drop > 0) m_drop--;
        else            m_cnt++;
      end
    end
    if (s_acc) begin
      n_cmp++;
      if (imem_req_addr !== m_next_req) begin
        n_err++;
        $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, m_next_req);
      end
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
      m_next_req += 32'd4;
    end
    if (s_pop) begin
      n_cmp++;
      if (if_pc !== m_exp_pc || if_instr !== memf(m_exp_pc)) begin
        n_err++;
        $display("FAIL stream_pop cyc=%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                 cyc, if_pc, if_instr, m_exp_pc, memf(m_exp_pc));
      end
      m_exp_pc += 32'd4;
      m_cnt--;
      n_consumed++;
    end
    if (redirect_valid) begin
      m_flush    = m_flush || (mq_addr.size() > 0);
      m_drop     = mq_addr.size();
      m_cnt      = 0;
      m_next_req = {redirect_pc[31:2], 2'b00};
      m_exp_pc   = {redirect_pc[31:2], 2'b00};
    end else if (m_flush && m_drop == 0) begin
      m_flush = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_cmp++;
    if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
    n_cmp++;
    if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_if_pc: got %h expected 0", if_pc); end
    n_cmp++;
    if (if_instr !== 32'h0) begin n_err++; $display("FAIL reset_if_instr: got %h expected 0", if_instr); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
    rdy_mode = 1; stall_mode = 0; lat_min = 1; lat_max = 1;
    rsp_rand = 1'b0; redir_pct = 0; redir_now = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (s_if_valid !== 1'b1 || s_if_pc !== 32'h0 || s_if_instr !== memf(32'h0)) begin
      n_err++;
      $display("FAIL reset_first_instr: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=%h",
               s_if_valid, s_if_pc, s_if_instr, memf(32'h0));
    end
    repeat (5) tick();
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    int          c0;
    stall_mode = 1;
    tick();
    pc0 = s_if_pc;
    repeat (4) tick();
    n_cmp++;
    if (s_if_valid !== 1'b1 || s_if_pc !== pc0 || s_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_hold: got v=%b pc=%h req=%b expected v=1 pc=%h req=0",
               s_if_valid, s_if_pc, s_req_valid, pc0);
    end
    stall_mode = 0;
    c0 = n_consumed;
    repeat (10) tick();
    n_cmp++;
    if (n_consumed - c0 < 5) begin
      n_err++;
      $display("FAIL stall_resume: got %0d consumed expected >=5", n_consumed - c0);
    end
  endtask

  task automatic test_redirect_inflight();
    bit got_req, got_pop, flushing;
    int n_dropped;
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && mq_addr.size() != 2; i++) tick();
    n_cmp++;
    if (mq_addr.size() != 2) begin
      n_err++;
      $display("FAIL inflight_setup: got %0d outstanding expected 2", mq_addr.size());
    end
    redir_now = 1'b1; redir_target = 32'h0000_0100;
    tick();
    redir_now = 1'b0;
    lat_min = 1; lat_max = 1;
    got_req = 1'b0; got_pop = 1'b0; n_dropped = 0;
    for (int i = 0; i < 40 && !(got_req && got_pop); i++) begin
      flushing = m_flush;
      tick();
      if (flushing && s_rsp) n_dropped++;
      if (s_acc && !got_req) begin
        got_req = 1'b1;
        n_cmp++;
        if (s_req_addr !== 32'h0000_0100) begin
          n_err++; $display("FAIL inflight_req_addr: got %h expected 00000100", s_req_addr);
        end
      end
      if (s_pop && !got_pop) begin
        got_pop = 1'b1;
        n_cmp++;
        if (s_if_pc !== 32'h0000_0100) begin
          n_err++; $display("FAIL inflight_if_pc: got %h expected 00000100", s_if_pc);
        end
      end
    end
    n_cmp++;
    if (!(got_req && got_pop) || n_dropped != 2) begin
      n_err++;
      $display("FAIL inflight_flush: got req=%b pop=%b dropped=%0d expected 1 1 2", got_req, got_pop, n_dropped);
    end
  endtask

  task automatic test_same_cycle();
    bit found;
    int d0;
    stall_mode = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) found = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL same_cycle_setup: got no pending response expected one"); end
    redir_now = 1'b1; redir_target = 32'h0000_0200;
    tick();
    redir_now = 1'b0;
    d0 = m_drop;
    tick();
    n_cmp++;
    if (s_if_valid !== 1'b0) begin n_err++; $display("FAIL same_cycle_empty: got if_valid=%b expected 0", s_if_valid); end
    n_cmp++;
    if (s_req_valid !== (d0 == 0)) begin
      n_err++; $display("FAIL same_cycle_req: got %b expected %b", s_req_valid, (d0 == 0));
    end
    stall_mode = 0;
    repeat (4) tick();
  endtask

  task automatic test_misaligned();
    bit got_req, got_pop;
    redir_now = 1'b1; redir_target = 32'h0000_0206;
    tick();
    redir_now = 1'b0;
    got_req = 1'b0; got_pop = 1'b0;
    for (int i = 0; i < 30 && !(got_req && got_pop); i++) begin
      tick();
      if (s_acc && !got_req) begin
        got_req = 1'b1;
        n_cmp++;
        if (s_req_addr !== 32'h0000_0204) begin
          n_err++; $display("FAIL misaligned_addr: got %h expected 00000204", s_req_addr);
        end
      end
      if (s_pop && !got_pop) begin
        got_pop = 1'b1;
        n_cmp++;
        if (s_if_pc !== 32'h0000_0204) begin
          n_err++; $display("FAIL misaligned_pc: got %h expected 00000204", s_if_pc);
        end
      end
    end
    n_cmp++;
    if (!(got_req && got_pop)) begin n_err++; $display("FAIL misaligned_timeout: got req=%b pop=%b expected 1 1", got_req, got_pop); end
  endtask

  task automatic test_wrap();
    bit found;
    rdy_mode = 0;
    redir_now = 1'b1; redir_target = 32'hFFFF_FFFC;
    tick();
    redir_now = 1'b0;
    for (int i = 0; i < 20 && m_flush; i++) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'hFFFF_FFFC) begin
        n_err++; $display("FAIL wrap_hold[%0d]: got v=%b addr=%h expected v=1 addr=fffffffc", i, s_req_valid, s_req_addr);
      end
    end
    rdy_mode = 1;
    tick();
    tick();
    n_cmp++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin
      n_err++; $display("FAIL wrap_next: got v=%b addr=%h expected v=1 addr=00000000", s_req_valid, s_req_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (s_if_valid && s_if_pc == 32'hFFFF_FFFC) found = 1'b1;
    end
    n_cmp++;
    if (!found || s_opcode !== 7'b0110011 || s_funct3 !== 3'b000 || s_funct7 !== 7'b0100000) begin
      n_err++;
      $display("FAIL decode_fields: got found=%b op=%b f3=%b f7=%b expected 1 0110011 000 0100000",
               found, s_opcode, s_funct3, s_funct7);
    end
  endtask

  task automatic test_random();
    int c0;
    rdy_mode = 2; stall_mode = 2; rsp_rand = 1'b1;
    lat_min = 1; lat_max = 4; redir_pct = 3;
    c0 = n_consumed;
    repeat (2000) tick();
    redir_pct = 0;
    n_cmp++;
    if (n_consumed - c0 < 100) begin
      n_err++; $display("FAIL random_progress: got %0d consumed expected >=100", n_consumed - c0);
    end
  endtask

  task automatic test_reset_midop();
    repeat (5) tick();
    rst = 1'b1;
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0) begin
      n_err++;
      $display("FAIL midop_reset: got req=%b v=%b pc=%h expected 0 0 0", imem_req_valid, if_valid, if_pc);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rdy_mode = 1; stall_mode = 0; rsp_rand = 1'b0; lat_min = 1; lat_max = 1;
    repeat (3) tick();
    n_cmp++;
    if (s_if_valid !== 1'b1 || s_if_pc !== 32'h0) begin
      n_err++; $display("FAIL midop_restart: got v=%b pc=%h expected v=1 pc=0", s_if_valid, s_if_pc);
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_inflight();
    test_same_cycle();
    test_misaligned();
    test_wrap();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
